sram_responder: RTL and testbench

On-chip stand-in for the external 16-bit asynchronous SRAM that the motherboard memory controller drives. It sits on the far end of the memAddrBus/memDataBus/memRead/memWrite/memEnable interface: it samples the controller's active-low strobes, commits writes into an internal block-RAM array, and drives read data back onto the shared tri-state data bus after a programmable latency. It lets the CPU and memory controller run on boards without populated SRAM, and gives the verification bench a cycle-exact memory target.

---
 rtl/sram_responder.sv | 181 ++++++++++++++++++
 tb/tb_sram_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// ============================================================================
// sram_responder : on-chip stand-in for a 16-bit asynchronous SRAM target.
// Optional statistics counters enabled by SRAM_RESPONDER_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_responder #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memAddrBus,
  inout  wire  [DATA_W-1:0] memDataBus,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memEnable,
  output logic              busDriving,
  output logic              contention,
  output logic [15:0]       rdCount,
  output logic [15:0]       wrCount
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DRIVE   = 2'd2,
    WR_ARM  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                contention_q;
  logic                commit;

  logic [DATA_W-1:0]   mem_q [0:DEPTH-1] = '{default: '0};

  // Strobes are active-low on the bus; work with active-high copies internally.
  logic ce, oe, we, addr_chg;
  assign ce       = ~memEnable;
  assign oe       = ~memRead;
  assign we       = ~memWrite;
  assign addr_chg = (memAddrBus != addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce && we) begin
          addr_d  = memAddrBus;
          wdata_d = memDataBus;
          state_d = WR_ARM;
        end else if (ce && oe) begin
          addr_d  = memAddrBus;
          cnt_d   = LAT_M1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ce && we) begin
          addr_d  = memAddrBus;
          wdata_d = memDataBus;
          state_d = WR_ARM;
        end else if (!ce || !oe) begin
          state_d = IDLE;
        end else if (addr_chg) begin
          addr_d = memAddrBus;
          cnt_d  = LAT_M1;
        end else if (cnt_q == 3'd0) begin
          rdata_d = mem_q[addr_q[DEPTH_LOG2-1:0]];
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DRIVE: begin
        if (!ce || !oe) begin
          state_d = IDLE;
        end else if (we) begin
          addr_d  = memAddrBus;
          wdata_d = memDataBus;
          state_d = WR_ARM;
        end else if (addr_chg) begin
          // Bus is released while the new word works through the latency.
          addr_d  = memAddrBus;
          cnt_d   = LAT_M1;
          state_d = RD_WAIT;
        end
      end
      WR_ARM: begin
        if (ce && we) begin
          addr_d  = memAddrBus;
          wdata_d = memDataBus;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array is deliberately outside reset; an aborted write never reaches it.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem_q[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      contention_q <= 1'b0;
    end else if (ce && oe && we) begin
      contention_q <= 1'b1;
    end
  end

  assign busDriving = (state_q == DRIVE);
  assign contention = contention_q;
  assign memDataBus = busDriving ? rdata_q : {DATA_W{1'bz}};

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic        rd_done;

  assign rd_done = (state_q == DRIVE) && (!ce || !oe);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_done && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (commit && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rdCount = rd_cnt_q;
  assign wrCount = wr_cnt_q;
`else
  assign rdCount = 16'd0;
  assign wrCount = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// tb_sram_responder : scoreboard bench driving two responders (READ_LAT 1 and 3)
// with identical strobes. Revision 1.0
// ============================================================================
`default_nettype none

module tb_sram_responder;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

`ifdef SRAM_RESPONDER_STATS_EN
  localparam logic [15:0] STATS_MASK = 16'hFFFF;
`else
  localparam logic [15:0] STATS_MASK = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr = '0;
  logic        oe_n = 1'b1;
  logic        we_n = 1'b1;
  logic        ce_n = 1'b1;
  logic        drv_en = 1'b0;
  logic [15:0] drv_data = '0;
  wire  [15:0] bus1, bus3;
  logic        busDriving1, busDriving3, contention1, contention3;
  logic [15:0] rdCount1, wrCount1, rdCount3, wrCount3;

  int   E = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic prev1 = 1'b0;
  logic prev3 = 1'b0;

  assign bus1 = drv_en ? drv_data : 16'bz;
  assign bus3 = drv_en ? drv_data : 16'bz;

  sram_responder #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .memAddrBus(addr), .memDataBus(bus1),
    .memRead(oe_n), .memWrite(we_n), .memEnable(ce_n),
    .busDriving(busDriving1), .contention(contention1),
    .rdCount(rdCount1), .wrCount(wrCount1));

  sram_responder #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .memAddrBus(addr), .memDataBus(bus3),
    .memRead(oe_n), .memWrite(we_n), .memEnable(ce_n),
    .busDriving(busDriving3), .contention(contention3),
    .rdCount(rdCount3), .wrCount(wrCount3));

  always #5 clk = ~clk;
  always @(posedge clk) E <= E + 1;

  function automatic logic [15:0] ex_cnt(input int v);
    return 16'(v) & STATS_MASK;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic mon_cmp(input string name, input int have_exp, input exp_t ex, input logic [15:0] bus);
    checks++;
    if (have_exp == 0) begin
      errors++;
      $display("FAIL %s: bus driven at edge %0d with %h, required no drive", name, E, bus);
    end else if (ex.cyc != E || bus !== ex.data) begin
      errors++;
      $display("FAIL %s: drive at edge %0d data %h, required edge %0d data %h",
               name, E, bus, ex.cyc, ex.data);
    end
  endtask

  // Monitors: each new bus drive consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t ex;
    int   have;
    if (busDriving1 && !prev1) begin
      have = q1.size();
      ex   = '{0, 16'h0};
      if (have != 0) ex = q1.pop_front();
      mon_cmp("drive_lat1", have, ex, bus1);
    end
    prev1 = busDriving1;
  end

  always @(negedge clk) begin
    exp_t ex;
    int   have;
    if (busDriving3 && !prev3) begin
      have = q3.size();
      ex   = '{0, 16'h0};
      if (have != 0) ex = q3.pop_front();
      mon_cmp("drive_lat3", have, ex, bus3);
    end
    prev3 = busDriving3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; drv_en = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int n);
    addr = a; drv_data = d; drv_en = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (n) step();
    idle();
    step();
  endtask

  // Detection edge k = E+1; LAT1 drives from k+1, LAT3 from k+3.
  task automatic do_read(input logic [17:0] a, input logic [15:0] d, input int h);
    int k;
    addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    k = E + 1;
    if (h >= 2) q1.push_back('{k + 1, d});
    if (h >= 4) q3.push_back('{k + 3, d});
    repeat (h) step();
    idle();
    step();
    step();
  endtask

  task automatic check_status(input string tag, input logic cont, input int rd, input int wr);
    chk({tag, "_busdrv1"}, 32'(busDriving1), 32'd0);
    chk({tag, "_busdrv3"}, 32'(busDriving3), 32'd0);
    chk({tag, "_cont1"}, 32'(contention1), 32'(cont));
    chk({tag, "_cont3"}, 32'(contention3), 32'(cont));
    chk({tag, "_rd1"}, 32'(rdCount1), 32'(ex_cnt(rd)));
    chk({tag, "_wr1"}, 32'(wrCount1), 32'(ex_cnt(wr)));
    chk({tag, "_rd3"}, 32'(rdCount3), 32'(ex_cnt(rd)));
    chk({tag, "_wr3"}, 32'(wrCount3), 32'(ex_cnt(wr)));
  endtask

  initial begin
    int k;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_status("reset", 1'b0, 0, 0);

    do_write(18'h00010, 16'hBEEF, 2);
    do_read(18'h00010, 16'hBEEF, 4);
    check_status("beef", 1'b0, 1, 1);

    do_write(18'h01005, 16'h1234, 1);
    do_read(18'h00005, 16'h1234, 4);

    do_write(18'h00020, 16'hAAAA, 1);
    do_write(18'h00021, 16'h5555, 3);
    // Address change after two sampled edges; both responders restart.
    addr = 18'h00020; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    k = E + 1;
    q1.push_back('{k + 1, 16'hAAAA});
    q1.push_back('{k + 3, 16'h5555});
    q3.push_back('{k + 5, 16'h5555});
    repeat (2) step();
    addr = 18'h00021;
    repeat (5) step();
    idle();
    step();
    step();
    check_status("addrchg", 1'b0, 3, 4);

    addr = 18'h00030; drv_data = 16'h00FF; drv_en = 1'b1;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    step();
    idle();
    step();
    chk("contention_set1", 32'(contention1), 32'd1);
    chk("contention_set3", 32'(contention3), 32'd1);
    do_read(18'h00030, 16'h00FF, 4);
    check_status("contention_hold", 1'b1, 4, 5);

    // Reset while both responders drive the bus.
    addr = 18'h00010; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    k = E + 1;
    q1.push_back('{k + 1, 16'hBEEF});
    q3.push_back('{k + 3, 16'hBEEF});
    repeat (4) step();
    chk("pre_rst_drv1", 32'(busDriving1), 32'd1);
    chk("pre_rst_drv3", 32'(busDriving3), 32'd1);
    rst = 1'b1;
    step();
    check_status("rst_mid_drive", 1'b0, 0, 0);
    rst = 1'b0;
    idle();
    step();

    do_read(18'h01005, 16'h1234, 4);
    do_read(18'h00010, 16'hBEEF, 5);
    check_status("retained", 1'b0, 2, 0);

    chk("scoreboard_empty1", 32'(q1.size()), 32'd0);
    chk("scoreboard_empty3", 32'(q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
